pdm_decimator: RTL
==================

PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter DECIM_LOG2, default 6, log2 of the decimation ratio R (R = 64); legal range 4..8.
REQ-002 clk  input  1  system clock (48 MHz internal oscillator domain).
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 din  input  1  PDM bitstream; 1 = +1, 0 = 0 (unipolar).
REQ-005 din_en  input  1  qualifies din; one PDM bit is consumed per clk with din_en=1.
REQ-006 sample  output  10  decoded unsigned amplitude, 0..1023.
REQ-007 valid  output  1  one-clk pulse; sample is new on this cycle.

Function
REQ-008 The block SHALL implement a 3rd-order CIC decimator: 3 cascaded integrators at PDM rate, decimate by R, then 3 cascaded combs (differential delay 1) at output rate.
REQ-009 Internal width SHALL be W = 3*DECIM_LOG2 + 1 bits (19 at default), with all integrator and comb arithmetic modulo 2^W (wrap-around is intended and required).
REQ-010 Integrators SHALL update only on cycles with din_en=1; with din_en=0 all state holds.
REQ-011 A phase counter of DECIM_LOG2 bits SHALL increment on each din_en cycle and wrap from R-1 to 0; the din_en cycle where it reads R-1 is the decimation tick.
REQ-012 On the decimation tick the comb chain SHALL process the third integrator's post-update value.
REQ-013 sample SHALL equal min(comb_out >> (3*DECIM_LOG2 - 10), 1023); full scale (comb_out = 2^(3*DECIM_LOG2)) saturates to 1023.
REQ-014 sample and valid SHALL be registered; valid pulses exactly one clk after the tick cycle and sample holds until the next valid.
REQ-015 Outputs SHALL appear once per R din_en cycles regardless of gaps in din_en.
REQ-016 din_en=1 on the cycle after a tick SHALL be accepted normally (no back-pressure, no dropped bits).

Reset
REQ-017 When rst=1 at a clk edge: integrators, comb delays, phase counter and settle counter SHALL clear to 0; sample=0; valid=0.
REQ-018 rst SHALL override din_en on the same edge; reset mid-frame discards the partial frame and the next tick occurs R din_en cycles after rst deasserts.

Configuration
REQ-019 Macro PDM_DECIM_SETTLE_EN: when defined, the first 3 decimation ticks after reset SHALL NOT pulse valid nor update sample (CIC transient suppressed); the 4th and later ticks behave per REQ-014.
REQ-020 Without PDM_DECIM_SETTLE_EN, every tick including the first SHALL produce valid; the settle counter SHALL not exist.

Structure
REQ-021 Package pdm_pkg SHALL hold SAMPLE_W = 10, CIC_ORDER = 3 and the width function W(DECIM_LOG2); shared with the pdm encoder.
REQ-022 One sub-module pdm_comb (single comb stage: register plus subtract, enable input) SHALL be instantiated 3 times; integrators and counter are inline.

Verification
REQ-023 din=1, din_en=1 continuous, settle enabled -> first valid at output 4 (clk 4*64+1 after reset release), sample = 1023 thereafter.
REQ-024 din=0 continuous -> every valid has sample = 0.
REQ-025 din alternating 1,0 with din_en=1 -> steady-state sample = 512 exactly.
REQ-026 din=1 with din_en high 1 clk in 3 -> valid spacing = 192 clk, steady sample = 1023.
REQ-027 rst pulsed at phase 37 of a frame -> valid=0 and sample=0 the next cycle; next valid 65 clk after rst release (64 din_en cycles).
REQ-028 Loopback from pdm encoder, din = 300 constant -> steady sample within 300 +/- 2.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM encoder/decoder family.
//   SAMPLE_W   : width of the decoded PCM amplitude
//   CIC_ORDER  : number of integrator/comb stages
//   cic_width(): internal CIC datapath width for a given log2 decimation ratio
package pdm_pkg;

    localparam int unsigned SAMPLE_W  = 10;
    localparam int unsigned CIC_ORDER = 3;

    // Bit growth of an order-N CIC on a 1-bit input is N*log2(R); one extra bit
    // lets full scale (exactly R^N) be represented without wrapping.
    function automatic int unsigned cic_width(input int unsigned decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/pdm_comb.sv
// Single CIC comb stage with differential delay 1.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the delay register
//   en   : decimation tick; captures x into the delay register
//   x    : stage input (modulo 2^W)
//   y_c  : combinational stage output, x minus previous captured input
module pdm_comb #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y_c
);

    logic [W-1:0] dly_q;

    // Delay register, advances at the decimated rate only
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else if (en) begin
            dly_q <= x;
        end
    end

    // Wrap-around subtraction is intentional: CIC relies on modulo arithmetic
    assign y_c = x - dly_q;

endmodule

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning a unipolar PDM bitstream into 10-bit PCM.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   din     : PDM bit (1 = +1, 0 = 0)
//   din_en  : qualifies din; one bit consumed per enabled clk
//   sample  : registered unsigned amplitude 0..1023, held between valids
//   valid   : registered one-clk pulse when sample is new
// Optional build macro PDM_DECIM_SETTLE_EN suppresses the first three outputs
// after reset while the CIC transient flushes.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    input  logic                din_en,
    output logic [SAMPLE_W-1:0] sample,
    output logic                valid
);

    localparam int unsigned W       = cic_width(DECIM_LOG2);
    localparam int unsigned SHIFT   = CIC_ORDER * DECIM_LOG2 - SAMPLE_W;
    localparam int unsigned SAT_MAX = (1 << SAMPLE_W) - 1;

    logic [W-1:0]          integ1_q, integ2_q, integ3_q;
    logic [W-1:0]          integ1_c, integ2_c, integ3_c;
    logic [DECIM_LOG2-1:0] phase_q;
    logic                  tick_c;
    logic                  publish_c;
    logic [W-1:0]          comb1_c, comb2_c, comb3_c;
    logic [W-1:0]          shifted_c;
    logic [SAMPLE_W-1:0]   sat_c;

    // Integrator cascade: each stage sees the freshly updated value of the one
    // before, so the tick can hand the comb chain the post-update total.
    always_comb begin
        integ1_c = integ1_q + W'(din);
        integ2_c = integ2_q + integ1_c;
        integ3_c = integ3_q + integ2_c;
    end

    assign tick_c = din_en && (phase_q == '1);

    // Integrators and phase counter advance only on enabled PDM bits
    always_ff @(posedge clk) begin
        if (rst) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
            phase_q  <= '0;
        end else if (din_en) begin
            integ1_q <= integ1_c;
            integ2_q <= integ2_c;
            integ3_q <= integ3_c;
            phase_q  <= phase_q + DECIM_LOG2'(1);
        end
    end

    // Comb chain evaluated combinationally on the tick; delays capture on tick
    pdm_comb #(.W(W)) u_comb1 (.clk(clk), .rst(rst), .en(tick_c), .x(integ3_c), .y_c(comb1_c));
    pdm_comb #(.W(W)) u_comb2 (.clk(clk), .rst(rst), .en(tick_c), .x(comb1_c),  .y_c(comb2_c));
    pdm_comb #(.W(W)) u_comb3 (.clk(clk), .rst(rst), .en(tick_c), .x(comb2_c),  .y_c(comb3_c));

    // Scale to SAMPLE_W bits; only full scale (R^3) exceeds the range
    always_comb begin
        shifted_c = comb3_c >> SHIFT;
        sat_c     = (shifted_c > W'(SAT_MAX)) ? SAMPLE_W'(SAT_MAX) : shifted_c[SAMPLE_W-1:0];
    end

`ifdef PDM_DECIM_SETTLE_EN
    logic [1:0] settle_q;

    // Counts the first three ticks after reset, then saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= '0;
        end else if (tick_c && (settle_q != 2'd3)) begin
            settle_q <= settle_q + 2'd1;
        end
    end

    assign publish_c = tick_c && (settle_q == 2'd3);
`else
    assign publish_c = tick_c;
`endif

    // Registered outputs: valid one clk after the tick, sample held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= publish_c;
            if (publish_c) begin
                sample <= sat_c;
            end
        end
    end

endmodule
